// File: rtl/hazard_flush_ctrl_pkg.sv
// Shared types and constants for the hazard sequencer: FSM state encoding,
// default register-index width and the hard-wired zero register index.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        MC_BUSY
    } hz_state_e;

    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned X0_IDX     = 0;

endpackage

// File: rtl/hazard_flush_ctrl_if.sv
// Pipeline <-> hazard sequencer bundle: decode/execute hazard inputs and
// the stall/flush/bubble controls plus status counters returned to the pipeline.
interface hazard_flush_ctrl_if
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) ();

    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              ex_branch_taken;
    logic              ex_mc_start;
    logic              ex_mc_done;

    logic              pc_stall;
    logic              ifid_stall;
    logic              ifid_flush;
    logic              idex_stall;
    logic              idex_flush;
    logic              exmem_bubble;
    logic              mc_timeout_err;
    logic [31:0]       perf_stall_cnt;
    logic [31:0]       perf_flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ex_mc_start, ex_mc_done,
        input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_bubble, mc_timeout_err, perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ex_mc_start, ex_mc_done,
        output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_bubble, mc_timeout_err, perf_stall_cnt, perf_flush_cnt
    );

endinterface

// File: rtl/hazard_flush_ctrl_load_use_det.sv
// Load-use detector: flags an ID source operand that depends on a load
// currently in EX. Writes to x0 never create a dependency.
module hazard_load_use_det
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              i_ex_mem_read,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    output logic              o_load_use
);

    logic w_rd_nz;
    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_rd_nz    = (i_ex_rd != REG_AW'(X0_IDX));
    assign w_hit_rs1  = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_hit_rs2  = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    assign o_load_use = i_ex_mem_read && w_rd_nz && (w_hit_rs1 || w_hit_rs2);

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: branch flush, load-use stall and
// multi-cycle EX stall with timeout. Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_flush_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MC_TIMEOUT   = 64,
    parameter int unsigned REG_AW       = REG_AW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_flush_ctrl_if.slave  hz
);

    localparam int unsigned    FCW          = 4;
    localparam int unsigned    MCW          = $clog2(MC_TIMEOUT + 1);
    localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(FLUSH_CYCLES - 1);
    localparam logic [MCW-1:0] MC_LIMIT     = MCW'(MC_TIMEOUT);

    hz_state_e      r_state;
    hz_state_e      w_state_nxt;
    logic [FCW-1:0] r_flush_cnt;
    logic [FCW-1:0] w_flush_cnt_nxt;
    logic [MCW-1:0] r_mc_cnt;
    logic [MCW-1:0] w_mc_cnt_nxt;
    logic           r_mc_err;
    logic           w_mc_err_set;
    logic           w_load_use;

    logic w_pc_stall;
    logic w_ifid_stall;
    logic w_ifid_flush;
    logic w_idex_stall;
    logic w_idex_flush;
    logic w_exmem_bubble;

    hazard_load_use_det #(
        .REG_AW (REG_AW)
    ) u_load_use_det (
        .i_ex_mem_read (hz.ex_mem_read),
        .i_ex_rd       (hz.ex_rd),
        .i_id_rs1      (hz.id_rs1),
        .i_id_rs2      (hz.id_rs2),
        .i_id_use_rs1  (hz.id_use_rs1),
        .i_id_use_rs2  (hz.id_use_rs2),
        .o_load_use    (w_load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
            r_mc_cnt    <= '0;
            r_mc_err    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_mc_cnt    <= w_mc_cnt_nxt;
            r_mc_err    <= r_mc_err | w_mc_err_set;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_mc_cnt_nxt    = r_mc_cnt;
        w_mc_err_set    = 1'b0;
        w_pc_stall      = 1'b0;
        w_ifid_stall    = 1'b0;
        w_ifid_flush    = 1'b0;
        w_idex_stall    = 1'b0;
        w_idex_flush    = 1'b0;
        w_exmem_bubble  = 1'b0;

        unique case (r_state)
            RUN: begin
                if (hz.ex_branch_taken) begin
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt     = FLUSH;
                        w_flush_cnt_nxt = FLUSH_RELOAD;
                    end
                end else if (hz.ex_mc_start) begin
                    // start+done together completes in one cycle: no stall at all
                    if (!hz.ex_mc_done) begin
                        w_pc_stall     = 1'b1;
                        w_ifid_stall   = 1'b1;
                        w_idex_stall   = 1'b1;
                        w_exmem_bubble = 1'b1;
                        w_state_nxt    = MC_BUSY;
                        w_mc_cnt_nxt   = MCW'(1);
                    end
                end else if (w_load_use) begin
                    w_pc_stall   = 1'b1;
                    w_ifid_stall = 1'b1;
                    w_idex_flush = 1'b1;
                end
            end

            FLUSH: begin
                w_ifid_flush = 1'b1;
                if (hz.ex_branch_taken) begin
                    w_idex_flush    = 1'b1;
                    w_flush_cnt_nxt = FLUSH_RELOAD;
                end else if (r_flush_cnt == FCW'(1)) begin
                    w_flush_cnt_nxt = '0;
                    w_state_nxt     = RUN;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - FCW'(1);
                end
            end

            MC_BUSY: begin
                if (hz.ex_mc_done) begin
                    w_mc_cnt_nxt = '0;
                    w_state_nxt  = RUN;
                end else if (r_mc_cnt == MC_LIMIT) begin
                    w_mc_err_set = 1'b1;
                    w_mc_cnt_nxt = '0;
                    w_state_nxt  = RUN;
                end else begin
                    w_pc_stall     = 1'b1;
                    w_ifid_stall   = 1'b1;
                    w_idex_stall   = 1'b1;
                    w_exmem_bubble = 1'b1;
                    w_mc_cnt_nxt   = r_mc_cnt + MCW'(1);
                end
            end

            default: begin
                w_state_nxt = RUN;
            end
        endcase

        // Controls are combinational, so mask them while reset is held
        if (!rst_n) begin
            w_pc_stall     = 1'b0;
            w_ifid_stall   = 1'b0;
            w_ifid_flush   = 1'b0;
            w_idex_stall   = 1'b0;
            w_idex_flush   = 1'b0;
            w_exmem_bubble = 1'b0;
        end
    end

    assign hz.pc_stall       = w_pc_stall;
    assign hz.ifid_stall     = w_ifid_stall;
    assign hz.ifid_flush     = w_ifid_flush;
    assign hz.idex_stall     = w_idex_stall;
    assign hz.idex_flush     = w_idex_flush;
    assign hz.exmem_bubble   = w_exmem_bubble;
    assign hz.mc_timeout_err = r_mc_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_pc_stall && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_ifid_flush && (r_perf_flush != '1)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign hz.perf_stall_cnt = r_perf_stall;
    assign hz.perf_flush_cnt = r_perf_flush;
`else
    assign hz.perf_stall_cnt = '0;
    assign hz.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Scoreboard bench for hazard_flush_ctrl: directed hazard scenarios followed by
// random traffic, checked against a timestamp-based reference model.
module tb_hazard_flush_ctrl;

    localparam int unsigned FC  = 3;
    localparam int unsigned MCT = 8;
    localparam int unsigned AW  = 5;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hazard_flush_ctrl_if #(.REG_AW(AW)) hz ();

    hazard_flush_ctrl #(
        .FLUSH_CYCLES (FC),
        .MC_TIMEOUT   (MCT),
        .REG_AW       (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    // ctl bits: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_bubble}
    typedef struct {
        logic [5:0]  ctl;
        logic        err;
        logic [31:0] ps;
        logic [31:0] pf;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: absolute-cycle timestamps of the active flush window and MC op
    int          cyc       = 0;
    int          flush_end = -1;
    bit          mc_on     = 1'b0;
    int          mc_begin  = 0;
    bit          m_err     = 1'b0;
    int unsigned m_ps      = 0;
    int unsigned m_pf      = 0;

    function automatic void check(input string nm, input int c,
                                  input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, c, act, exp);
        end
    endfunction

    task automatic drive(input logic rst, input logic br, input logic st, input logic dn,
                         input logic mr, input logic [AW-1:0] rd, input logic [AW-1:0] r1,
                         input logic [AW-1:0] r2, input logic u1, input logic u2);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        rst_n              = rst;
        hz.ex_branch_taken = br;
        hz.ex_mc_start     = st;
        hz.ex_mc_done      = dn;
        hz.ex_mem_read     = mr;
        hz.ex_rd           = rd;
        hz.id_rs1          = r1;
        hz.id_rs2          = r2;
        hz.id_use_rs1      = u1;
        hz.id_use_rs2      = u2;

        e.cyc = cyc;
        e.ctl = '0;
        e.err = m_err;
        e.ps  = m_ps;
        e.pf  = m_pf;
        lu = mr && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));

        if (!rst) begin
            flush_end = -1;
            mc_on     = 1'b0;
            m_err     = 1'b0;
            m_ps      = 0;
            m_pf      = 0;
            e.err     = 1'b0;
            e.ps      = 0;
            e.pf      = 0;
        end else if (mc_on) begin
            if (dn) begin
                mc_on = 1'b0;
            end else if (cyc - mc_begin == int'(MCT)) begin
                m_err = 1'b1;
                mc_on = 1'b0;
            end else begin
                e.ctl = 6'b110101;
            end
        end else if (cyc <= flush_end) begin
            e.ctl[3] = 1'b1;
            if (br) begin
                e.ctl[1]  = 1'b1;
                flush_end = cyc + int'(FC) - 1;
            end
        end else if (br) begin
            e.ctl     = 6'b001010;
            flush_end = cyc + int'(FC) - 1;
        end else if (st) begin
            if (!dn) begin
                e.ctl    = 6'b110101;
                mc_on    = 1'b1;
                mc_begin = cyc;
            end
        end else if (lu) begin
            e.ctl = 6'b110010;
        end

`ifdef HAZARD_PERF_CNT_EN
        if (rst) begin
            m_ps += 32'(e.ctl[5]);
            m_pf += 32'(e.ctl[3]);
        end
`else
        e.ps = '0;
        e.pf = '0;
`endif
        cyc++;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_cycle();
        logic rst, br, st, dn, mr, u1, u2;
        logic [AW-1:0] rd, r1, r2;
        rst = ($urandom_range(0, 199) != 0);
        br  = ($urandom_range(0, 9) == 0);
        st  = ($urandom_range(0, 11) == 0);
        dn  = ($urandom_range(0, 5) == 0);
        mr  = ($urandom_range(0, 1) == 1);
        u1  = ($urandom_range(0, 1) == 1);
        u2  = ($urandom_range(0, 1) == 1);
        rd  = AW'($urandom_range(0, 3));
        r1  = AW'($urandom_range(0, 3));
        r2  = AW'($urandom_range(0, 3));
        drive(rst, br, st, dn, mr, rd, r1, r2, u1, u2);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("ctl", e.cyc, 32'({hz.pc_stall, hz.ifid_stall, hz.ifid_flush,
                                         hz.idex_stall, hz.idex_flush, hz.exmem_bubble}), 32'(e.ctl));
                check("mc_timeout_err", e.cyc, 32'(hz.mc_timeout_err), 32'(e.err));
                check("perf_stall_cnt", e.cyc, hz.perf_stall_cnt, e.ps);
                check("perf_flush_cnt", e.cyc, hz.perf_flush_cnt, e.pf);
            end
        end
    end

    initial begin : stimulus
        rst_n              = 1'b0;
        hz.ex_branch_taken = 1'b0;
        hz.ex_mc_start     = 1'b0;
        hz.ex_mc_done      = 1'b0;
        hz.ex_mem_read     = 1'b0;
        hz.ex_rd           = '0;
        hz.id_rs1          = '0;
        hz.id_rs2          = '0;
        hz.id_use_rs1      = 1'b0;
        hz.id_use_rs2      = 1'b0;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 1, 5, 5, 0, 1, 0);
        idle(2);

        // load-use on rs1, x0 guard, load-use on rs2, unused operand
        drive(1, 0, 0, 0, 1, 5, 5, 0, 1, 0);
        idle(1);
        drive(1, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 1, 7, 1, 7, 0, 1);
        drive(1, 0, 0, 0, 1, 7, 7, 7, 0, 0);
        idle(1);

        // branch flush window, then a branch restarting an active window
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        drive(1, 1, 0, 0, 1, 5, 5, 0, 1, 0);
        idle(3);

        // multi-cycle op done in cycle 4 with load-use present during the stall
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 1, 5, 5, 0, 1, 0);
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(1);

        // start and done together, then start beating load-use
        drive(1, 0, 1, 1, 1, 5, 5, 0, 1, 0);
        drive(1, 0, 1, 0, 1, 5, 5, 0, 1, 0);
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        // timeout with no done, sticky error afterwards
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(MCT + 3);

        // branch beats load-use
        drive(1, 1, 0, 0, 1, 5, 5, 5, 1, 1);
        idle(3);

        // reset in the middle of a multi-cycle stall
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 3000; i++) rand_cycle();
        idle(2);

        repeat (3) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
